// File: rtl/axi_ar_allocator_rr_if.sv
// AR-channel bundle for axi_ar_allocator_rr: N request ports in, one registered AR port out,
// plus the R-channel completion snoop. Modport slave is the allocator's view, master the driver's.
interface axi_ar_allocator_rr_if #(
    parameter int AXI_ADDRESS_W = 32,
    parameter int AXI_USER_W    = 6,
    parameter int N_TARG_PORT   = 7,
    parameter int LOG_N_TARG    = $clog2(N_TARG_PORT),
    parameter int AXI_ID_IN     = 16,
    parameter int AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG
);
    logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]     arid_i;
    logic [N_TARG_PORT-1:0][AXI_ADDRESS_W-1:0] araddr_i;
    logic [N_TARG_PORT-1:0][7:0]               arlen_i;
    logic [N_TARG_PORT-1:0][2:0]               arsize_i;
    logic [N_TARG_PORT-1:0][1:0]               arburst_i;
    logic [N_TARG_PORT-1:0]                    arlock_i;
    logic [N_TARG_PORT-1:0][3:0]               arcache_i;
    logic [N_TARG_PORT-1:0][2:0]               arprot_i;
    logic [N_TARG_PORT-1:0][3:0]               arregion_i;
    logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]    aruser_i;
    logic [N_TARG_PORT-1:0][3:0]               arqos_i;
    logic [N_TARG_PORT-1:0]                    arvalid_i;
    logic [N_TARG_PORT-1:0]                    arready_o;

    logic [AXI_ID_OUT-1:0]    arid_o;
    logic [AXI_ADDRESS_W-1:0] araddr_o;
    logic [7:0]               arlen_o;
    logic [2:0]               arsize_o;
    logic [1:0]               arburst_o;
    logic                     arlock_o;
    logic [3:0]               arcache_o;
    logic [2:0]               arprot_o;
    logic [3:0]               arregion_o;
    logic [AXI_USER_W-1:0]    aruser_o;
    logic [3:0]               arqos_o;
    logic                     arvalid_o;
    logic                     arready_i;

    logic                  rvalid_i;
    logic                  rready_i;
    logic                  rlast_i;
    logic [AXI_ID_OUT-1:0] rid_i;

    modport slave (
        input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arlock_i, arcache_i,
               arprot_i, arregion_i, aruser_i, arqos_i, arvalid_i,
        output arready_o,
        output arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arlock_o, arcache_o,
               arprot_o, arregion_o, aruser_o, arqos_o, arvalid_o,
        input  arready_i,
        input  rvalid_i, rready_i, rlast_i, rid_i
    );

    modport master (
        output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arlock_i, arcache_i,
               arprot_i, arregion_i, aruser_i, arqos_i, arvalid_i,
        input  arready_o,
        input  arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arlock_o, arcache_o,
               arprot_o, arregion_o, aruser_o, arqos_o, arvalid_o,
        output arready_i,
        output rvalid_i, rready_i, rlast_i, rid_i
    );
endinterface

// File: rtl/axi_ar_allocator_rr.sv
// Round-robin AR allocator with a registered output beat; the winner's index is prepended to its ID.
// Define AXI_AR_ALLOC_OUTSTANDING_LIMIT_EN to cap outstanding reads per port at MAX_OUTSTANDING.
module axi_ar_allocator_rr #(
    parameter int AXI_ADDRESS_W   = 32,
    parameter int AXI_USER_W      = 6,
    parameter int N_TARG_PORT     = 7,
    parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
    parameter int AXI_ID_IN       = 16,
    parameter int AXI_ID_OUT      = AXI_ID_IN + LOG_N_TARG,
    parameter int MAX_OUTSTANDING = 8
) (
    input logic                  clk,
    input logic                  rst,
    axi_ar_allocator_rr_if.slave bus
);
    typedef struct packed {
        logic [AXI_ID_OUT-1:0]    id;
        logic [AXI_ADDRESS_W-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
        logic                     lock;
        logic [3:0]               cache;
        logic [2:0]               prot;
        logic [3:0]               region;
        logic [AXI_USER_W-1:0]    user;
        logic [3:0]               qos;
    } beat_t;

    beat_t                  beat_q, beat_d;
    logic                   valid_q, valid_d;
    logic [LOG_N_TARG-1:0]  ptr_q, ptr_d;
    logic [LOG_N_TARG-1:0]  win;
    logic                   found, load_en, accept;
    logic [N_TARG_PORT-1:0] eligible, blocked, arready;

    always_comb begin : arbiter
        logic [LOG_N_TARG:0] idx;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win      = '0;
        found    = 1'b0;
        eligible = bus.arvalid_i & ~blocked;
        for (int k = 0; k < N_TARG_PORT; k++) begin
            idx = {1'b0, ptr_q} + (LOG_N_TARG+1)'(k);
            if (idx >= (LOG_N_TARG+1)'(N_TARG_PORT)) idx = idx - (LOG_N_TARG+1)'(N_TARG_PORT);
            if (!found && eligible[idx[LOG_N_TARG-1:0]]) begin
                found = 1'b1;
                win   = idx[LOG_N_TARG-1:0];
            end
        end
    end

    always_comb begin : next_state
        load_en = ~valid_q | bus.arready_i;
        accept  = load_en & found;
        valid_d = load_en ? found : valid_q;
        beat_d  = beat_q;
        ptr_d   = ptr_q;
        arready = '0;
        if (accept) begin
            beat_d.id     = {win, bus.arid_i[win]};
            beat_d.addr   = bus.araddr_i[win];
            beat_d.len    = bus.arlen_i[win];
            beat_d.size   = bus.arsize_i[win];
            beat_d.burst  = bus.arburst_i[win];
            beat_d.lock   = bus.arlock_i[win];
            beat_d.cache  = bus.arcache_i[win];
            beat_d.prot   = bus.arprot_i[win];
            beat_d.region = bus.arregion_i[win];
            beat_d.user   = bus.aruser_i[win];
            beat_d.qos    = bus.arqos_i[win];
            ptr_d         = (win == LOG_N_TARG'(N_TARG_PORT-1)) ? '0 : win + 1'b1;
            // Ready is suppressed during reset since the idle register would otherwise accept.
            arready[win]  = ~rst;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef AXI_AR_ALLOC_OUTSTANDING_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

    logic [N_TARG_PORT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_TARG_PORT-1:0]            inc, dec_req, dec;
    logic                              r_done;
    logic [LOG_N_TARG-1:0]             r_port;

    always_comb begin : outstanding
        r_done = bus.rvalid_i & bus.rready_i & bus.rlast_i;
        r_port = bus.rid_i[AXI_ID_OUT-1:AXI_ID_IN];
        for (int i = 0; i < N_TARG_PORT; i++) begin
            inc[i]     = accept && (win == LOG_N_TARG'(i));
            dec_req[i] = r_done && (r_port == LOG_N_TARG'(i));
            dec[i]     = dec_req[i] && (cnt_q[i] != '0);
            cnt_d[i]   = cnt_q[i];
            if (inc[i] && !dec[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else if (dec[i] && !inc[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
            // Registered count only: a same-cycle completion frees the slot next cycle.
            blocked[i] = (cnt_q[i] == CNT_W'(MAX_OUTSTANDING));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    for (genvar g = 0; g < N_TARG_PORT; g++) begin : g_underflow_chk
        assert property (@(posedge clk) disable iff (rst) !(dec_req[g] && cnt_q[g] == '0));
    end
`else
    localparam int unused_max_outstanding = MAX_OUTSTANDING;
    logic unused_r;
    assign blocked  = '0;
    assign unused_r = ^{bus.rvalid_i, bus.rready_i, bus.rlast_i, bus.rid_i};
`endif

    assign bus.arready_o  = arready;
    assign bus.arvalid_o  = valid_q;
    assign bus.arid_o     = beat_q.id;
    assign bus.araddr_o   = beat_q.addr;
    assign bus.arlen_o    = beat_q.len;
    assign bus.arsize_o   = beat_q.size;
    assign bus.arburst_o  = beat_q.burst;
    assign bus.arlock_o   = beat_q.lock;
    assign bus.arcache_o  = beat_q.cache;
    assign bus.arprot_o   = beat_q.prot;
    assign bus.arregion_o = beat_q.region;
    assign bus.aruser_o   = beat_q.user;
    assign bus.arqos_o    = beat_q.qos;
endmodule

// File: tb/tb_axi_ar_allocator_rr.sv
// Self-checking bench for axi_ar_allocator_rr: vector table, hand-written corner sequences,
// and randomized traffic against a queue-free round-robin reference model.
module tb_axi_ar_allocator_rr;
    localparam int AW  = 32;
    localparam int UW  = 6;
    localparam int N   = 7;
    localparam int LOG = $clog2(N);
    localparam int IDI = 16;
    localparam int IDO = IDI + LOG;
`ifdef AXI_AR_ALLOC_OUTSTANDING_LIMIT_EN
    localparam int MAX_OUT  = 2;
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam int MAX_OUT  = 8;
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_ar_allocator_rr_if #(.AXI_ADDRESS_W(AW), .AXI_USER_W(UW), .N_TARG_PORT(N),
                             .LOG_N_TARG(LOG), .AXI_ID_IN(IDI), .AXI_ID_OUT(IDO)) bus ();

    axi_ar_allocator_rr #(.AXI_ADDRESS_W(AW), .AXI_USER_W(UW), .N_TARG_PORT(N),
                          .LOG_N_TARG(LOG), .AXI_ID_IN(IDI), .AXI_ID_OUT(IDO),
                          .MAX_OUTSTANDING(MAX_OUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] in_beat(input int p);
        return 128'({bus.araddr_i[p], bus.arlen_i[p], bus.arsize_i[p], bus.arburst_i[p],
                     bus.arlock_i[p], bus.arcache_i[p], bus.arprot_i[p], bus.arregion_i[p],
                     bus.aruser_i[p], bus.arqos_i[p]});
    endfunction

    function automatic logic [127:0] out_beat();
        return 128'({bus.araddr_o, bus.arlen_o, bus.arsize_o, bus.arburst_o, bus.arlock_o,
                     bus.arcache_o, bus.arprot_o, bus.arregion_o, bus.aruser_o, bus.arqos_o});
    endfunction

    task automatic set_payload(input int p, input bit rnd);
        if (rnd) begin
            bus.arid_i[p]     = IDI'($urandom);
            bus.araddr_i[p]   = AW'($urandom);
            bus.arlen_i[p]    = 8'($urandom);
            bus.arsize_i[p]   = 3'($urandom);
            bus.arburst_i[p]  = 2'($urandom);
            bus.arlock_i[p]   = 1'($urandom);
            bus.arcache_i[p]  = 4'($urandom);
            bus.arprot_i[p]   = 3'($urandom);
            bus.arregion_i[p] = 4'($urandom);
            bus.aruser_i[p]   = UW'($urandom);
            bus.arqos_i[p]    = 4'($urandom);
        end else begin
            bus.arid_i[p]     = IDI'(16'h0100 + p);
            bus.araddr_i[p]   = 32'h2000_0000 + AW'(p * 64);
            bus.arlen_i[p]    = 8'(p + 1);
            bus.arsize_i[p]   = 3'(p);
            bus.arburst_i[p]  = 2'(p % 3);
            bus.arlock_i[p]   = 1'(p);
            bus.arcache_i[p]  = 4'(p);
            bus.arprot_i[p]   = 3'(7 - p);
            bus.arregion_i[p] = 4'(p + 8);
            bus.aruser_i[p]   = UW'(p * 5);
            bus.arqos_i[p]    = 4'(15 - p);
        end
    endtask

    task automatic drive_idle();
        bus.arvalid_i = '0;
        bus.arready_i = 1'b0;
        bus.rvalid_i  = 1'b0;
        bus.rready_i  = 1'b0;
        bus.rlast_i   = 1'b0;
        bus.rid_i     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: drive at the falling edge, sample just after, the DUT updates on the next rising edge.
    task automatic step(input logic [N-1:0] vld, input logic rdy);
        @(negedge clk);
        rst           = 1'b0;
        bus.arvalid_i = vld;
        bus.arready_i = rdy;
        #1;
    endtask

    typedef struct {
        logic [N-1:0] arvalid;
        logic         rdy;
        logic [N-1:0] exp_arready;
        logic         exp_valid;
        int           exp_idx;
    } vec_t;

    vec_t vecs[14];

    // Reference model state
    bit           m_valid;
    int           m_ptr;
    logic [127:0] m_beat;
    logic [IDO-1:0] m_id;
    int           m_cnt[N];

    initial begin
        // Round robin from reset, then idle, then ports 2 and 5 with the pointer sitting at 4.
        for (int k = 0; k < 8; k++)
            vecs[k] = '{7'h7F, 1'b1, N'(1 << (k % 7)), (k > 0), (k + 6) % 7};
        vecs[8]  = '{7'h00, 1'b1, 7'h00, 1'b1, 0};
        vecs[9]  = '{7'h08, 1'b1, 7'h08, 1'b0, 0};
        vecs[10] = '{7'h24, 1'b1, 7'h20, 1'b1, 3};
        vecs[11] = '{7'h24, 1'b1, 7'h04, 1'b1, 5};
        vecs[12] = '{7'h00, 1'b1, 7'h00, 1'b1, 2};
        vecs[13] = '{7'h00, 1'b1, 7'h00, 1'b0, 0};

        drive_idle();
        for (int p = 0; p < N; p++) set_payload(p, 1'b0);
        bus.arvalid_i = '1;
        bus.arready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_arready", bus.arready_o, 0);
        check("reset_arvalid", bus.arvalid_o, 0);
        check("reset_arid", bus.arid_o, 0);
        check("reset_payload", out_beat(), 0);

        foreach (vecs[i]) begin
            step(vecs[i].arvalid, vecs[i].rdy);
            check($sformatf("vec%0d_arready", i), bus.arready_o, vecs[i].exp_arready);
            check($sformatf("vec%0d_arvalid", i), bus.arvalid_o, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_arid", i), bus.arid_o,
                      {LOG'(vecs[i].exp_idx), IDI'(16'h0100 + vecs[i].exp_idx)});
                check($sformatf("vec%0d_payload", i), out_beat(), in_beat(vecs[i].exp_idx));
            end
        end

        // Stall: port 3 held for four cycles with downstream not ready.
        do_reset();
        bus.arid_i[3]   = 16'h00A5;
        bus.araddr_i[3] = 32'h1000_0040;
        step(7'h08, 1'b0);
        check("stall_first_accept", bus.arready_o, 7'h08);
        for (int c = 0; c < 4; c++) begin
            step(7'h08, 1'b0);
            check("stall_arvalid", bus.arvalid_o, 1);
            check("stall_arid", bus.arid_o, {3'd3, 16'h00A5});
            check("stall_araddr", bus.araddr_o, 32'h1000_0040);
            check("stall_arready", bus.arready_o, 0);
        end
        step(7'h00, 1'b1);
        check("stall_release_valid", bus.arvalid_o, 1);
        check("stall_release_araddr", bus.araddr_o, 32'h1000_0040);
        step(7'h00, 1'b1);
        check("stall_drained", bus.arvalid_o, 0);
        set_payload(3, 1'b0);

`ifdef AXI_AR_ALLOC_OUTSTANDING_LIMIT_EN
        // Port 1 limited to two outstanding reads; the third waits for an R last beat.
        do_reset();
        step(7'h02, 1'b1); check("lim_grant1", bus.arready_o, 7'h02);
        step(7'h02, 1'b1); check("lim_grant2", bus.arready_o, 7'h02);
        step(7'h02, 1'b1); check("lim_blocked_a", bus.arready_o, 0);
        step(7'h02, 1'b1); check("lim_blocked_b", bus.arready_o, 0);
        bus.rvalid_i = 1'b1; bus.rready_i = 1'b1; bus.rlast_i = 1'b1;
        bus.rid_i    = {LOG'(1), 16'h0100};
        #1;
        check("lim_same_cycle_still_blocked", bus.arready_o, 0);
        step(7'h02, 1'b1);
        bus.rvalid_i = 1'b0; bus.rlast_i = 1'b0;
        #1;
        check("lim_grant_after_r", bus.arready_o, 7'h02);
        // Accept and completion on port 0 in the same cycle leaves its count unchanged.
        do_reset();
        step(7'h01, 1'b1); check("same_grant1", bus.arready_o, 7'h01);
        step(7'h01, 1'b1);
        bus.rvalid_i = 1'b1; bus.rready_i = 1'b1; bus.rlast_i = 1'b1;
        bus.rid_i    = {LOG'(0), 16'h0100};
        #1;
        check("same_grant2", bus.arready_o, 7'h01);
        step(7'h01, 1'b1);
        bus.rvalid_i = 1'b0; bus.rlast_i = 1'b0;
        #1;
        check("same_grant3", bus.arready_o, 7'h01);
        step(7'h01, 1'b1); check("same_blocked", bus.arready_o, 0);
        step(7'h02, 1'b1); // leave port 1 with a nonzero count before the mid-run reset
        step(7'h02, 1'b1);
`endif

        // Reset while a beat is held: the beat is dropped and arbitration restarts at port 0.
        step(7'h10, 1'b0);
        step(7'h7F, 1'b0);
        check("mid_held_valid", bus.arvalid_o, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_arready", bus.arready_o, 0);
        step(7'h00, 1'b0);
        check("mid_after_valid", bus.arvalid_o, 0);
        check("mid_after_payload", out_beat(), 0);
        check("mid_after_arid", bus.arid_o, 0);
        step(7'h7F, 1'b1);
        check("mid_ptr_zero", bus.arready_o, 7'h01);
        step(7'h02, 1'b1);
        check("mid_cnt_clear_a", bus.arready_o, 7'h02);
        step(7'h02, 1'b1);
        check("mid_cnt_clear_b", bus.arready_o, 7'h02);

        // Randomized traffic against the reference model.
        do_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_beat  = '0;
        m_id    = '0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit           load, found, fire;
            int           w, q;
            logic [N-1:0] exp_rdy;
            @(negedge clk);
            for (int p = 0; p < N; p++) set_payload(p, 1'b1);
            bus.arvalid_i = N'($urandom);
            bus.arready_i = ($urandom_range(0, 3) != 0);
            q    = $urandom_range(0, N);
            fire = ($urandom_range(0, 2) == 0) && (q >= N || m_cnt[q] > 0);
            bus.rvalid_i = fire;
            bus.rready_i = fire;
            bus.rlast_i  = 1'($urandom);
            bus.rid_i    = {LOG'((q < N) ? q : (1 << LOG) - 1), IDI'($urandom)};
            #1;
            load  = !m_valid || bus.arready_i;
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (!found && bus.arvalid_i[p] && (!LIMIT_EN || m_cnt[p] < MAX_OUT)) begin
                    found = 1'b1;
                    w     = p;
                end
            end
            exp_rdy = (load && found) ? N'(1 << w) : '0;
            check("rnd_arready", bus.arready_o, exp_rdy);
            check("rnd_arvalid", bus.arvalid_o, m_valid);
            if (m_valid) begin
                check("rnd_arid", bus.arid_o, m_id);
                check("rnd_payload", out_beat(), m_beat);
            end
            if (load) begin
                m_valid = found;
                if (found) begin
                    m_beat = in_beat(w);
                    m_id   = {LOG'(w), bus.arid_i[w]};
                    m_ptr  = (w + 1) % N;
                    m_cnt[w]++;
                end
            end
            if (fire && bus.rlast_i && q < N && m_cnt[q] > 0) m_cnt[q]--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
